// File: rtl/vec_alu_seq.sv
// Element sequencer feeding the scalar ALU: walks one vector instruction element by
// element, collects results and zero flags, and hands back a packed result vector.
module vec_alu_seq #(
  parameter int VLEN = 8,
  parameter int DW   = 32,
  parameter int VLW  = $clog2(VLEN+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [VLEN*DW-1:0]  va,
  input  logic [VLEN*DW-1:0]  vb,
  input  logic [VLW-1:0]      vl,
  input  logic [3:0]          op,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [3:0]          alu_sel,
  input  logic [DW-1:0]       alu_result,
  input  logic                alu_z,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [VLEN*DW-1:0]  vr,
  output logic [VLEN-1:0]     zmask,
  output logic                err
);
  localparam int IW = (VLEN > 1) ? $clog2(VLEN) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                  r_state;
  logic [VLEN-1:0][DW-1:0] r_va, r_vb, r_vr;
  logic [VLEN-1:0]         r_zmask;
  logic [3:0]              r_op;
  logic [VLW-1:0]          r_vl;
  logic [IW-1:0]           r_idx;
  logic                    r_in_ready, r_out_valid, r_err;

  logic [VLW-1:0] w_vl_clamp;
  logic           w_last;

  assign w_vl_clamp = (vl > VLW'(VLEN)) ? VLW'(VLEN) : vl;
  assign w_last     = (VLW'(r_idx) == r_vl - VLW'(1));

  // Index parks at 0 outside EXEC, so the ALU sees element 0 while idle/done.
  // An illegal op is forced to 0 so the ALU never sees a code above 7.
  assign alu_a   = r_va[r_idx];
  assign alu_b   = r_vb[r_idx];
  assign alu_sel = r_op[3] ? 4'd0 : r_op;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign vr        = r_vr;
  assign zmask     = r_zmask;
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_va        <= '0;
      r_vb        <= '0;
      r_vr        <= '0;
      r_zmask     <= '0;
      r_op        <= '0;
      r_vl        <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_va       <= va;
            r_vb       <= vb;
            r_op       <= op;
            r_vl       <= w_vl_clamp;
            r_vr       <= '0;
            r_zmask    <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            if (op[3]) begin
              r_err       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_vl_clamp == '0) begin
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= EXEC;
            end
          end
        end
        EXEC: begin
          r_vr[r_idx]    <= alu_result;
          r_zmask[r_idx] <= alu_z;
          if (w_last) begin
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/vec_alu_seq.md
Name: vec_alu_seq

Overview:
- Element sequencer that sits directly upstream of the scalar 32-bit ALU in the vector processing unit.
- Accepts one vector instruction: two operand vectors, a vector length and a 4-bit op. Issues one element pair per cycle to the ALU, captures the result and zero flag for that element, and presents the packed result vector plus a per-element zero mask downstream.
- Valid/ready handshake on both the instruction side and the result side.

Parameters:
- VLEN, 8, maximum elements per vector; must be at least 1.
- DW, 32, element width; fixed to match the ALU.
- VLW, $clog2(VLEN+1), width of the vector-length field.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  sequencer can accept an instruction.
- va  in  VLEN*DW  operand A vector; element i is va[i*DW +: DW].
- vb  in  VLEN*DW  operand B vector; same packing as va.
- vl  in  VLW  number of active elements.
- op  in  4  ALU operation code: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra.
- alu_a  out  DW  element A to ALU, signed.
- alu_b  out  DW  element B to ALU.
- alu_sel  out  4  op to ALU.
- alu_result  in  DW  combinational result from ALU.
- alu_z  in  1  ALU zero flag.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts the result.
- vr  out  VLEN*DW  result vector; same packing as va.
- zmask  out  VLEN  bit i = alu_z of element i; 0 for inactive elements.
- err  out  1  illegal op; qualified by out_valid.

Behaviour:
- Reset: when rst=1 at a clock edge:
  - state goes to IDLE;
  - in_ready=1, out_valid=0, err=0;
  - vr=0, zmask=0, alu_a=0, alu_b=0, alu_sel=0;
  - element index cleared.
- rst asserted mid-operation aborts the instruction; no partial result is ever presented.
- States: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch va, vb and op, and latch vl clamped to VLEN (vl>VLEN is treated as VLEN). Clear vr and zmask. Index=0.
  - If op>7: set err=1 and go to DONE (no elements issued).
  - Else if clamped vl=0: go to DONE with err=0.
  - Else: go to EXEC.
- EXEC:
  - in_ready=0.
  - alu_a, alu_b and alu_sel are driven combinationally from the latched operands at the current index.
  - Each cycle, write alu_result into vr element [index] and alu_z into zmask[index], then increment index.
  - When index = vl-1 (the last element), go to DONE.
  - One element per cycle: accepted instruction to out_valid is vl+1 cycles; for the vl=0 or illegal-op cases it is 1 cycle.
- DONE:
  - out_valid=1; vr, zmask and err are held stable.
  - On out_ready=1: out_valid drops next cycle, state returns to IDLE, err clears.
  - out_ready=0 stalls indefinitely with outputs unchanged.
  - Back-pressure never reaches the ALU.
- alu_sel is never driven above 7, so the ALU default (X) path is never exercised.
- Outside EXEC, alu_a, alu_b and alu_sel hold the values of element 0 of the latched operands. Downstream must not rely on them.
- Inactive elements (index >= vl) stay 0 in vr and 0 in zmask.
- No arithmetic is done in this block. Results wrap exactly as the ALU produces them. Shift amount is alu_b[4:0], handled inside the ALU.
- in_valid while busy (in_ready=0) is ignored. The upstream must hold the instruction until in_ready=1.
- Throughput: back-to-back instructions have at least one IDLE cycle between DONE and the next EXEC.

Test Plan:
- Add, vl=4:
  - Stimulus: va={1,2,3,-5}, vb={1,-2,7,5}, op=0.
  - Response: out_valid exactly 5 cycles after accept; vr={2,0,10,0,0,0,0,0}; zmask=8'b0000_1010; err=0.
- Clamp, vl=12 (exceeds VLEN=8):
  - Stimulus: op=1 (sub), va=vb, all 0x0000_0010.
  - Response: 8 elements processed; vr all 0; zmask=8'hFF; out_valid 9 cycles after accept.
- Illegal op and vl=0:
  - op=9, vl=3 -> out_valid next cycle, err=1, vr=0, zmask=0, alu_sel never >7.
  - op=0, vl=0 -> out_valid next cycle, err=0, vr=0, zmask=0.
- Back-pressure:
  - Stimulus: out_ready held 0 for 10 cycles in DONE (op=7, va[0]=32'h8000_0000, vb[0]=4, vl=1).
  - Response: vr[0]=32'hF800_0000 held stable; in_valid pulses ignored; release accepts exactly one result.
- Reset mid-EXEC:
  - Stimulus: rst=1 at element 2 of vl=6.
  - Response: next cycle in_ready=1, out_valid=0, vr=0, zmask=0. A fresh instruction then completes correctly.
